alu_serial_seq: RTL

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

---
 rtl/alu_ctrl_pkg.sv | 34 +++
 rtl/alu_slice.sv | 46 ++++
 rtl/alu_serial_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the bit-serial ALU: default datapath width, the
// 4-bit ALU_control codes {A_invert, B_invert, operation[1:0]}, the 2-bit
// operation selector and the sequencer state encoding.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

   localparam int ALU_WIDTH = 32;

   // Full ALU_control codes. Codes outside this list are still executed
   // bit-for-bit from their fields.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Slice operation field, ALU_control[1:0].
   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SLT = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/alu_slice.sv
// ---------------------------------------------------------------------------
// alu_slice
// Purely combinational 1-bit ALU slice (MIPS-style).
//   src1, src2  : operand bits
//   less        : value passed through for the SLT operation
//   A_invert    : invert src1 before use
//   B_invert    : invert src2 before use
//   cin         : carry into this bit
//   operation   : 00 AND, 01 OR, 10 ADD, 11 SLT (less)
//   result      : selected output bit
//   cout        : carry out of the full adder (valid for every operation)
// ---------------------------------------------------------------------------
module alu_slice
   import alu_ctrl_pkg::*;
(
   input  logic       src1,
   input  logic       src2,
   input  logic       less,
   input  logic       A_invert,
   input  logic       B_invert,
   input  logic       cin,
   input  logic [1:0] operation,
   output logic       result,
   output logic       cout
);

   logic a_eff;
   logic b_eff;
   logic sum;

   always_comb begin
      a_eff = src1 ^ A_invert;
      b_eff = src2 ^ B_invert;
      sum   = a_eff ^ b_eff ^ cin;
      cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
      // NOTE: every branch assigns result and the case has a default, so no
      // latch can be inferred from this combinational block.
      case (operation)
         OP_AND:  result = a_eff & b_eff;
         OP_OR:   result = a_eff | b_eff;
         OP_ADD:  result = sum;
         default: result = less;
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// ---------------------------------------------------------------------------
// alu_serial_seq
// Bit-serial ALU: one 1-bit alu_slice is reused WIDTH times, LSB first, to
// produce a WIDTH-bit AND/OR/ADD/SUB/SLT/NOR result plus flags.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request an operation (only looked at while idle)
//   src1, src2   : operands, captured with ALU_control when start is taken
//   ALU_control  : {A_invert, B_invert, operation[1:0]}
//   busy         : an operation is in progress
//   done         : one-cycle pulse, result/flags updated
//   result       : final result, held until the next done
//   zero         : result == 0
//   cout         : carry out of the MSB (arithmetic operations only)
//   overflow     : signed overflow (arithmetic operations only)
// Latency: done is high in the cycle after edge E0+WIDTH+1.
// ---------------------------------------------------------------------------
module alu_serial_seq
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       ctrl_q;
   logic [WIDTH-1:0] acc_q;       // result bits, shifted in from the top
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic             cin_msb_q;   // carry into bit WIDTH-1
   logic             sum_msb_q;   // raw adder sum of bit WIDTH-1

   logic             load;
   logic             step;
   logic             finish;

   logic             a_inv;
   logic             b_inv;
   logic [1:0]       op;
   logic             a_bit;
   logic             b_bit;
   logic             slice_res;
   logic             slice_cout;
   logic             msb_sum;

   logic             ovf_fin;
   logic             set_fin;
   logic             arith;
   logic [WIDTH-1:0] res_fin;

   assign a_inv = ctrl_q[3];
   assign b_inv = ctrl_q[2];
   assign op    = ctrl_q[1:0];
   assign a_bit = a_q[idx_q];
   assign b_bit = b_q[idx_q];

   alu_slice u_slice (
      .src1      (a_bit),
      .src2      (b_bit),
      .less      (1'b0),
      .A_invert  (a_inv),
      .B_invert  (b_inv),
      .cin       (carry_q),
      .operation (op),
      .result    (slice_res),
      .cout      (slice_cout)
   );

   // The slice outputs less (0) for SLT, so the MSB adder sum needed for the
   // set bit is formed here from the same effective inputs.
   assign msb_sum = (a_bit ^ a_inv) ^ (b_bit ^ b_inv) ^ carry_q;

   // ---------------- sequencer: state register ----------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- sequencer: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (idx_q == IDX_LAST) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- sequencer: outputs ----------------
   always_comb begin
      busy   = 1'b0;
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE: load = start;
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
         end
         FIN: begin
            busy   = 1'b1;
            finish = 1'b1;
         end
         default: ;
      endcase
   end

   // Final flag/result formation, used only in FIN when carry_q holds the
   // carry out of the MSB.
   always_comb begin
      ovf_fin = cin_msb_q ^ carry_q;
      set_fin = sum_msb_q ^ ovf_fin;
      arith   = op[1];
      res_fin = (op == OP_SLT) ? WIDTH'(set_fin) : acc_q;
   end

   // ---------------- datapath and output registers ----------------
   // NOTE: the operand/control latches are reset as well; they are tiny and a
   // reset value keeps the idle datapath free of unknowns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         ctrl_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         cin_msb_q <= 1'b0;
         sum_msb_q <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         cout      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            a_q     <= src1;
            b_q     <= src2;
            ctrl_q  <= ALU_control;
            idx_q   <= '0;
            carry_q <= ALU_control[2];   // +1 of two's-complement negate
         end
         if (step) begin
            acc_q   <= {slice_res, acc_q[WIDTH-1:1]};
            carry_q <= slice_cout;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               cin_msb_q <= carry_q;
               sum_msb_q <= msb_sum;
            end
         end
         if (finish) begin
            result   <= res_fin;
            zero     <= (res_fin == '0);
            cout     <= arith & carry_q;
            overflow <= arith & ovf_fin;
            done     <= 1'b1;
         end
      end
   end

endmodule
